// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: IDLE -> REQ -> DONE, with an optional REQ timeout into FAULT.
// Define IFETCH_TIMEOUT_EN to enable the mem_ack timeout counter and the FAULT state.
module instr_fetch #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] pc,
    output logic            mem_rd,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            pc_ld,
    output logic [XLEN-1:0] pc_data,
    output logic [XLEN-1:0] ir,
    output logic            done,
    output logic            busy,
    output logic            fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] ir_q;
    logic            capture;
    logic            ack_taken;

    assign ack_taken = (state == S_REQ) && mem_ack;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    // A fetch may be (re)started from IDLE or from FAULT.
    assign capture = ((state == S_IDLE) || (state == S_FAULT)) && fetch_req;

    // An ack in the expiry cycle takes priority over the timeout.
    assign tmo_hit = (state == S_REQ) && !mem_ack && (tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (capture) begin
            tmo_cnt <= '0;
        end else if ((state == S_REQ) && !mem_ack) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end
`else
    assign capture = (state == S_IDLE) && fetch_req;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fetch_req) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_nxt = S_DONE;
                end
`ifdef IFETCH_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = S_FAULT;
                end
`endif
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
`ifdef IFETCH_TIMEOUT_EN
                if (fetch_req) begin
                    state_nxt = S_REQ;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= S_IDLE;
            addr_q <= '0;
            ir_q   <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                addr_q <= pc;
            end
            if (ack_taken) begin
                ir_q <= mem_rdata;
            end
        end
    end

    // All strobes decode from state so reset clears them on the same edge.
    assign mem_rd   = (state == S_REQ);
    assign mem_addr = addr_q;
    assign pc_ld    = (state == S_DONE);
    assign done     = (state == S_DONE);
    assign pc_data  = addr_q + XLEN'(4);
    assign ir       = ir_q;
    assign busy     = (state != S_IDLE);

`ifdef IFETCH_TIMEOUT_EN
    assign fault = (state == S_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the driver queues expected fetch outcomes,
// a negedge monitor checks strobes, address, latency, pc_data and ir every cycle.
module tb_instr_fetch;

    localparam int XLEN = 32;
    localparam int TMO  = 16;

    logic            clk;
    logic            rstn;
    logic            fetch_req;
    logic [XLEN-1:0] pc;
    logic            mem_rd;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;
    logic            pc_ld;
    logic [XLEN-1:0] pc_data;
    logic [XLEN-1:0] ir;
    logic            done;
    logic            busy;
    logic            fault;

    typedef struct {
        int          start;
        int          fin;
        logic [31:0] addr;
        logic [31:0] next_pc;
        logic [31:0] ir;
    } exp_t;

    exp_t        sb[$];
    int          cyc      = 0;
    int          n_cmp    = 0;
    int          n_err    = 0;
    logic        mon_en   = 1'b0;
    logic [31:0] exp_ir   = '0;
    logic [31:0] exp_addr = '0;

    instr_fetch #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .fetch_req (fetch_req),
        .pc        (pc),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_ld     (pc_ld),
        .pc_data   (pc_data),
        .ir        (ir),
        .done      (done),
        .busy      (busy),
        .fault     (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One fetch: request in relative cycle 0, ack in cycle k, DONE in k+1.
    // Non-IDLE cycles carry random fetch_req/pc noise and stray acks, which must be ignored.
    task automatic applyStimulus(input logic [31:0] pcv, input int k, input logic [31:0] rdata, input int gap);
        fetch_req = 1'b1;
        pc        = pcv;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        sb.push_back('{cyc, cyc + k + 1, pcv, pcv + 32'd4, rdata});
        tick();
        for (int i = 1; i < k; i++) begin
            fetch_req = 1'($urandom);
            pc        = $urandom;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            tick();
        end
        fetch_req = 1'($urandom);
        pc        = $urandom;
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        fetch_req = 1'($urandom);
        pc        = $urandom;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        tick();
        for (int g = 0; g < gap; g++) begin
            fetch_req = 1'b0;
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            tick();
        end
        fetch_req = 1'b0;
        mem_ack   = 1'b0;
    endtask

    // Monitor: expected behaviour derived from the queued transaction windows.
    initial begin
        forever begin
            logic exp_busy;
            logic exp_rd;
            logic exp_done;
            exp_t e;
            @(negedge clk);
            if (mon_en) begin
                exp_busy = 1'b0;
                exp_rd   = 1'b0;
                exp_done = 1'b0;
                if (sb.size() > 0) begin
                    e = sb[0];
                    if (cyc > e.start) begin
                        exp_addr = e.addr;
                        exp_busy = 1'b1;
                        exp_rd   = (cyc < e.fin);
                        exp_done = (cyc == e.fin);
                    end
                end
                if (exp_done) begin
                    exp_ir = e.ir;
                end
                checkOutput("mon_mem_rd", 32'(mem_rd), 32'(exp_rd));
                checkOutput("mon_pc_ld", 32'(pc_ld), 32'(exp_done));
                checkOutput("mon_done", 32'(done), 32'(exp_done));
                checkOutput("mon_busy", 32'(busy), 32'(exp_busy));
                checkOutput("mon_mem_addr", mem_addr, exp_addr);
                checkOutput("mon_ir", ir, exp_ir);
                checkOutput("mon_fault", 32'(fault), 32'd0);
                if (exp_done) begin
                    checkOutput("mon_pc_data", pc_data, e.next_pc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rstn      = 1'b0;
        fetch_req = 1'b0;
        pc        = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("rst_pc_ld", 32'(pc_ld), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ir", ir, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        rstn = 1'b1;
        tick();
        mon_en = 1'b1;

        applyStimulus(32'h0000_0100, 3, 32'h0050_0093, 0);
        applyStimulus(32'h0000_0200, 1, 32'hA5A5_0001, 0);
        applyStimulus(32'h0000_0204, 1, 32'hA5A5_0002, 0);
        applyStimulus(32'hFFFF_FFFC, 2, 32'h1357_9BDF, 1);

        // Reset in the middle of REQ abandons the fetch; a later ack does nothing.
        mon_en    = 1'b0;
        fetch_req = 1'b1;
        pc        = 32'h0000_2000;
        tick();
        fetch_req = 1'b0;
        checkOutput("midrst_mem_rd", 32'(mem_rd), 32'd1);
        checkOutput("midrst_mem_addr", mem_addr, 32'h0000_2000);
        rstn = 1'b0;
        tick();
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_mem_rd_after", 32'(mem_rd), 32'd0);
        checkOutput("midrst_ir", ir, 32'd0);
        checkOutput("midrst_addr", mem_addr, 32'd0);
        rstn      = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        checkOutput("midrst_ack_pc_ld", 32'(pc_ld), 32'd0);
        checkOutput("midrst_ack_busy", 32'(busy), 32'd0);
        checkOutput("midrst_ack_ir", ir, 32'd0);
        tick();
        checkOutput("midrst_ack_done", 32'(done), 32'd0);
        exp_ir   = '0;
        exp_addr = '0;

`ifdef IFETCH_TIMEOUT_EN
        fetch_req = 1'b1;
        pc        = 32'h0000_3000;
        tick();
        fetch_req = 1'b0;
        for (int i = 1; i <= TMO; i++) begin
            checkOutput("tmo_wait_fault", 32'(fault), 32'd0);
            checkOutput("tmo_wait_mem_rd", 32'(mem_rd), 32'd1);
            tick();
        end
        checkOutput("tmo_fault", 32'(fault), 32'd1);
        checkOutput("tmo_mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("tmo_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
            tick();
            checkOutput("tmo_hold_fault", 32'(fault), 32'd1);
            checkOutput("tmo_hold_ir", ir, 32'd0);
        end
        mem_ack   = 1'b0;
        fetch_req = 1'b1;
        pc        = 32'h0000_4000;
        tick();
        fetch_req = 1'b0;
        checkOutput("tmo_clear_fault", 32'(fault), 32'd0);
        checkOutput("tmo_refetch_mem_rd", 32'(mem_rd), 32'd1);
        checkOutput("tmo_refetch_addr", mem_addr, 32'h0000_4000);
        for (int i = 1; i < TMO; i++) tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        checkOutput("expiry_ack_pc_ld", 32'(pc_ld), 32'd1);
        checkOutput("expiry_ack_fault", 32'(fault), 32'd0);
        checkOutput("expiry_ack_pc_data", pc_data, 32'h0000_4004);
        checkOutput("expiry_ack_ir", ir, 32'h1234_5678);
        tick();
        checkOutput("expiry_idle_busy", 32'(busy), 32'd0);
        exp_ir   = 32'h1234_5678;
        exp_addr = 32'h0000_4000;
        mon_en   = 1'b1;
`else
        mon_en = 1'b1;
        applyStimulus(32'h0000_5000, TMO + 4, 32'h0BAD_F00D, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            applyStimulus({$urandom} & 32'hFFFF_FFFC, int'($urandom_range(6, 1)),
                          $urandom, int'($urandom_range(2, 0)));
        end
        applyStimulus(32'hFFFF_FFFC, 1, 32'hCAFE_0000, 0);

        repeat (4) tick();
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
